// File: rtl/alu_if.sv
// Operand/result bundle between the datapath controller and the ALU.
// There is no handshake: op/tr/sr are consumed on every rising clock edge and
// dr/cf/of always hold the result of the operands present at the previous edge.
interface alu_if #(
  parameter int WIDTH = 32
);
  logic [3:0]       op;
  logic [WIDTH-1:0] tr;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] dr;
  logic             cf;
  logic             of;

  // Controller side: supplies the opcode and operands, observes result and flags.
  modport master (
    output op, tr, sr,
    input  dr, cf, of
  );

  // ALU side: consumes the opcode and operands, produces result and flags.
  modport slave (
    input  op, tr, sr,
    output dr, cf, of
  );
endinterface

// File: rtl/alu.sv
// Registered integer ALU: dr = tr OP sr with carry and signed-overflow flags,
// one cycle of latency, updated on every rising clock edge.
module alu #(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  rst_n,
  alu_if.slave  bus
);
  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_CMP = 4'b0101;
  localparam logic [3:0] OP_MOV = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SLR = 4'b1001;
  localparam logic [3:0] OP_SRL = 4'b1010;
  localparam logic [3:0] OP_SRA = 4'b1011;

  logic [SW-1:0]    n;
  logic [SW:0]      rot_r;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   shl;
  logic [WIDTH:0]   shr;
  logic [WIDTH:0]   sha;
  logic [WIDTH-1:0] rol;
  logic             add_of;
  logic             sub_of;
  logic [WIDTH-1:0] dr_nxt;
  logic             cf_nxt;
  logic             of_nxt;

  // Shared arithmetic and shifter datapaths. The shifters carry one extra
  // bit so the last bit shifted out lands in a fixed position (the carry).
  always_comb begin
    n      = bus.sr[SW-1:0];
    rot_r  = (SW+1)'(WIDTH) - {1'b0, n};
    sum    = {1'b0, bus.tr} + {1'b0, bus.sr};
    diff   = {1'b0, bus.tr} - {1'b0, bus.sr};
    shl    = {1'b0, bus.tr} << n;
    shr    = {bus.tr, 1'b0} >> n;
    sha    = $signed({bus.tr, 1'b0}) >>> n;
    // n = 0 makes rot_r = WIDTH, so the right-hand term shifts to zero.
    rol    = (bus.tr << n) | (bus.tr >> rot_r);
    add_of = (bus.tr[WIDTH-1] == bus.sr[WIDTH-1]) &&
             (sum[WIDTH-1] != bus.tr[WIDTH-1]);
    sub_of = (bus.tr[WIDTH-1] != bus.sr[WIDTH-1]) &&
             (diff[WIDTH-1] != bus.tr[WIDTH-1]);
  end

  // Opcode decode; reserved and unknown opcodes fall to the all-zero default.
  always_comb begin
    dr_nxt = '0;
    cf_nxt = 1'b0;
    of_nxt = 1'b0;
    case (bus.op)
      OP_ADD: begin
        dr_nxt = sum[WIDTH-1:0];
        cf_nxt = sum[WIDTH];
        of_nxt = add_of;
      end
      OP_SUB, OP_CMP: begin
        dr_nxt = diff[WIDTH-1:0];
        cf_nxt = diff[WIDTH];
        of_nxt = sub_of;
      end
      OP_AND: dr_nxt = bus.tr & bus.sr;
      OP_OR:  dr_nxt = bus.tr | bus.sr;
      OP_XOR: dr_nxt = bus.tr ^ bus.sr;
      OP_MOV: dr_nxt = bus.sr;
      OP_SLL: begin
        dr_nxt = shl[WIDTH-1:0];
        cf_nxt = shl[WIDTH];
      end
      OP_SLR: begin
        dr_nxt = rol;
        cf_nxt = (n != '0) ? rol[0] : 1'b0;
      end
      OP_SRL: begin
        dr_nxt = shr[WIDTH:1];
        cf_nxt = shr[0];
      end
      OP_SRA: begin
        dr_nxt = sha[WIDTH:1];
        cf_nxt = sha[0];
      end
      default: begin
        dr_nxt = '0;
        cf_nxt = 1'b0;
        of_nxt = 1'b0;
      end
    endcase
  end

  // Result and flag registers; async reset discards any pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.dr <= '0;
      bus.cf <= 1'b0;
      bus.of <= 1'b0;
    end else begin
      bus.dr <= dr_nxt;
      bus.cf <= cf_nxt;
      bus.of <= of_nxt;
    end
  end
endmodule

// File: tb/tb_alu.sv
// Directed bench for the registered ALU: reset behaviour, op sweeps,
// flag corner cases, shift edges, latency and reserved opcodes.
module tb_alu;
  localparam int W = 32;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  // Expected {dr, cf, of} values waiting to be compared.
  logic [W+1:0] exp_q[$];

  alu_if #(.WIDTH(W)) bus ();

  alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed {dr,cf,of} against the expected value.
  task automatic chk(input string tag, input logic [W+1:0] obs, input logic [W+1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed dr=%h cf=%b of=%b expected dr=%h cf=%b of=%b",
             tag, obs[W+1:2], obs[1], obs[0], exp[W+1:2], exp[1], exp[0]);
    end
  endtask

  // Drive one operation, wait for the capturing edge, then check the popped expectation.
  task automatic step(input string tag, input logic [3:0] op, input logic [W-1:0] tr,
                      input logic [W-1:0] sr, input logic [W-1:0] edr,
                      input logic ecf, input logic eof);
    logic [W+1:0] e;
    exp_q.push_back({edr, ecf, eof});
    bus.op = op;
    bus.tr = tr;
    bus.sr = sr;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk(tag, {bus.dr, bus.cf, bus.of}, e);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.op = 4'b0000;
    bus.tr = 32'd5;
    bus.sr = 32'd7;

    // Reset held with the clock running
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hold", {bus.dr, bus.cf, bus.of}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset asserted between edges after a nonzero result
    step("pre_reset_add", 4'b0000, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {bus.dr, bus.cf, bus.of}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Arithmetic/logic sweep
    step("add",  4'b0000, 32'd32, 32'd21, 32'd53, 1'b0, 1'b0);
    step("sub",  4'b0001, 32'd32, 32'd21, 32'd11, 1'b0, 1'b0);
    step("and",  4'b0010, 32'd32, 32'd21, 32'd0,  1'b0, 1'b0);
    step("or",   4'b0011, 32'd32, 32'd21, 32'd53, 1'b0, 1'b0);
    step("xor",  4'b0100, 32'd32, 32'd21, 32'd53, 1'b0, 1'b0);
    step("cmp",  4'b0101, 32'd32, 32'd21, 32'd11, 1'b0, 1'b0);
    step("mov",  4'b0110, 32'd32, 32'd21, 32'd21, 1'b0, 1'b0);
    step("r0111", 4'b0111, 32'd32, 32'd21, 32'd0, 1'b0, 1'b0);
    step("and_mix", 4'b0010, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1'b0);

    // Shift sweep
    step("sll", 4'b1000, 32'd32, 32'd3, 32'd256, 1'b0, 1'b0);
    step("slr", 4'b1001, 32'd32, 32'd3, 32'd256, 1'b0, 1'b0);
    step("srl", 4'b1010, 32'd32, 32'd3, 32'd4,   1'b0, 1'b0);
    step("sra", 4'b1011, 32'd32, 32'd3, 32'd4,   1'b0, 1'b0);

    // Flags
    step("add_carry", 4'b0000, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 1'b1, 1'b0);
    step("add_ovf",   4'b0000, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1);
    step("sub_ovf",   4'b0001, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1);
    step("sub_borrow", 4'b0001, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b1, 1'b0);
    step("cmp_borrow", 4'b0101, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b1, 1'b0);

    // Shift edges
    step("sra_31",  4'b1011, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, 1'b0);
    step("srl_cf",  4'b1010, 32'h0000_0003, 32'd1,  32'h0000_0001, 1'b1, 1'b0);
    step("sll_cf",  4'b1000, 32'h8000_0001, 32'd1,  32'h0000_0002, 1'b1, 1'b0);
    step("slr_cf",  4'b1001, 32'h8000_0001, 32'd1,  32'h0000_0003, 1'b1, 1'b0);
    step("sra_neg", 4'b1011, 32'hF000_0008, 32'd4,  32'hFF00_0000, 1'b1, 1'b0);
    step("sll_0",   4'b1000, 32'h8765_4321, 32'd0,  32'h8765_4321, 1'b0, 1'b0);
    step("slr_0",   4'b1001, 32'h8765_4321, 32'd32, 32'h8765_4321, 1'b0, 1'b0);
    step("srl_0",   4'b1010, 32'h8765_4321, 32'd0,  32'h8765_4321, 1'b0, 1'b0);
    step("sra_0",   4'b1011, 32'h8765_4321, 32'd64, 32'h8765_4321, 1'b0, 1'b0);
    step("srl_35",  4'b1010, 32'd32,        32'd35, 32'd4,         1'b0, 1'b0);
    step("srl_35cf", 4'b1010, 32'h0000_000F, 32'd35, 32'h0000_0001, 1'b1, 1'b0);
    step("sll_35",  4'b1000, 32'h8000_0001, 32'd35, 32'h0000_0008, 1'b0, 1'b0);
    step("slr_8",   4'b1001, 32'h1234_5678, 32'd8,  32'h3456_7812, 1'b0, 1'b0);

    // Latency: inputs changed mid-cycle must not disturb dr until the next edge
    step("lat_first", 4'b0000, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0);
    bus.tr = 32'd5;
    bus.sr = 32'd5;
    #2;
    chk("lat_hold", {bus.dr, bus.cf, bus.of}, {32'd2, 1'b0, 1'b0});
    bus.op = 4'b0001;
    bus.tr = 32'd9;
    bus.sr = 32'd4;
    @(posedge clk);
    #1;
    chk("lat_update", {bus.dr, bus.cf, bus.of}, {32'd5, 1'b0, 1'b0});

    // Reserved opcodes after a nonzero result
    step("r1100", 4'b1100, 32'd32, 32'd21, 32'd0, 1'b0, 1'b0);
    step("pre_r", 4'b0110, 32'd32, 32'd21, 32'd21, 1'b0, 1'b0);
    step("r1101", 4'b1101, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0);
    step("r1110", 4'b1110, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0);
    step("r1111", 4'b1111, 32'd3, 32'd5, 32'd0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu.md
Name: alu

Overview:
- Registered 32-bit integer ALU for the CPU datapath.
- Computes dr = tr OP sr for a 4-bit opcode, and produces carry (cf) and signed-overflow (of) flags.
- tr is the destination-register operand; sr is the source operand, or the shift amount for shift ops.
- Results and flags are captured on the rising clock edge and feed the register-file writeback and flag register.

Parameters:
- WIDTH, 32, data width of tr/sr/dr. Must be a power of two ≥ 8. Shift amount uses the low log2(WIDTH) bits of sr.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- op  input  4  operation select
- tr  input  WIDTH  first operand (destination register value)
- sr  input  WIDTH  second operand / shift amount
- dr  output  WIDTH  registered result
- cf  output  1  registered carry/borrow/shift-out flag
- of  output  1  registered signed-overflow flag

Behaviour:
- Reset: rst_n low asynchronously forces dr=0, cf=0, of=0, held while low. First capture is on the first rising clk edge after rst_n rises. Reset asserted mid-operation discards the pending result.
- Timing: purely combinational next-state from op/tr/sr. dr/cf/of are updated on every rising clk edge, so latency is 1 cycle. There is no handshake or enable, and outputs change only at clock edges.
- Opcodes (n = sr[log2(WIDTH)-1:0]; all arithmetic modulo 2^WIDTH):
  - 0000 ADD: dr=tr+sr; cf=unsigned carry out; of=signed overflow (operands same sign, result sign differs).
  - 0001 SUB: dr=tr-sr; cf=borrow (1 iff tr<sr unsigned); of=signed overflow (operand signs differ, result sign differs from tr).
  - 0010 AND: dr=tr&sr; cf=0; of=0.
  - 0011 OR: dr=tr|sr; cf=0; of=0.
  - 0100 XOR: dr=tr^sr; cf=0; of=0.
  - 0101 CMP: dr, cf, of computed exactly as SUB. Suppressing register writeback is the controller's job.
  - 0110 MOV: dr=sr; cf=0; of=0.
  - 0111 reserved: dr=0; cf=0; of=0.
  - 1000 SLL: dr=tr<<n, zero fill; cf=last bit shifted out (tr[WIDTH-n]), 0 when n=0; of=0.
  - 1001 SLR (rotate left): dr=(tr<<n)|(tr>>(WIDTH-n)); cf=dr[0] when n≠0, else 0; of=0. n=0 gives dr=tr.
  - 1010 SRL: dr=tr>>n, zero fill; cf=tr[n-1], 0 when n=0; of=0.
  - 1011 SRA: dr=tr>>>n, sign fill; cf=tr[n-1], 0 when n=0; of=0.
  - 1100–1111 reserved: dr=0; cf=0; of=0.
- Shift amount: upper bits of sr above log2(WIDTH) are ignored (sr=33 shifts by 1 for WIDTH=32).
- X/unknown op must not latch: the default branch applies the reserved behaviour.

Test Plan:
- Reset: hold rst_n=0 with clock running → dr=0, cf=0, of=0. Assert rst_n low between edges after a nonzero result → outputs clear immediately, without waiting for a clock edge.
- Arithmetic/logic sweep, tr=32, sr=21, one op per cycle, checked one edge after application:
  - ADD → 53
  - SUB → 11, cf=0
  - AND → 0
  - OR → 53
  - XOR → 53
  - CMP → 11
  - MOV → 21
  - op 0111 → 0
  - All flags 0 throughout.
- Shift sweep, tr=32, sr=3:
  - SLL → 256
  - SLR → 256
  - SRL → 4
  - SRA → 4
  - cf=0 for all four.
- Flags:
  - ADD 0xFFFFFFFF+1 → dr=0, cf=1, of=0.
  - ADD 0x7FFFFFFF+1 → dr=0x80000000, cf=0, of=1.
  - SUB 0x80000000-1 → dr=0x7FFFFFFF, cf=0, of=1.
  - SUB 3-5 → dr=0xFFFFFFFE, cf=1, of=0.
- Shift edges:
  - SRA 0x80000000 by 31 → 0xFFFFFFFF, cf=0.
  - SRL 0x00000003 by 1 → 1, cf=1.
  - SLL 0x80000001 by 1 → 2, cf=1.
  - SLR 0x80000001 by 1 → 3, cf=1.
  - Any shift by 0 → dr=tr, cf=0.
  - sr=35 behaves as shift by 3.
- Latency: change op/tr/sr mid-cycle → dr stable until the next rising edge, then reflects the values present at that edge. Reserved ops 1100–1111 → dr=0, cf=0, of=0.
